// File: rtl/adder_seq_ctrl.sv
// Wide adder built from one WIDTH-bit slice, one chunk per cycle, with the carry held in a register.
// The result is valid CHUNKS cycles after acceptance and is held in DONE until out_ready; no request is taken while busy.
module adder_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*CHUNKS-1:0] a,
  input  logic [WIDTH*CHUNKS-1:0] b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*CHUNKS-1:0] sum,
  output logic                    cout,
  output logic                    busy
);

  localparam int N  = WIDTH * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     sum_q;
  logic             carry;
  logic             cout_q;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_sl;
  logic [WIDTH-1:0] b_sl;
  logic [WIDTH:0]   slice;

  always_comb begin
    a_sl  = a_q[idx*WIDTH +: WIDTH];
    b_sl  = b_q[idx*WIDTH +: WIDTH];
    slice = {1'b0, a_sl} + {1'b0, b_sl} + {{WIDTH{1'b0}}, carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            sum_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*WIDTH +: WIDTH] <= slice[WIDTH-1:0];
          carry                     <= slice[WIDTH];
          // idx parks on the last chunk rather than wrapping; acceptance clears it.
          if (idx == LAST) begin
            cout_q <= slice[WIDTH];
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
